payment_controller: RTL and testbench
=====================================

Name: payment_controller

Overview:
- Payment stage of the vending machine, sitting between the raw coin inputs and the product/change holding FSMs.
- Debounces coin inputs and accumulates credit. Compares credit against the price of the one-hot product selection and issues the one-cycle EN that releases the product.
- Issues change as a serial train of change codes on V, and generates the duration pulses z_1 (dispense hold elapsed) and z2 (change hold elapsed) consumed downstream.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized cycles required to accept a coin level change.
- DISP_CYCLES, 8: cycles from EN to the z_1 pulse.
- CHG_CYCLES, 4: cycles from each V code to its z2 pulse.
- PRICE0, 2: price in units of product P=0001.
- PRICE1, 3: price of product P=0010.
- PRICE2, 4: price of product P=0100.
- PRICE3, 5: price of product P=1000. All prices are in the range 1..15.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin1  in  1  raw 1-unit coin/bill contact, asynchronous and bouncy.
- coin2  in  1  raw 2-unit coin/bill contact, asynchronous and bouncy.
- cancel  in  1  raw refund button; ignored unless PAYMENT_CANCEL_EN is defined.
- P  in  4  held product selection, one-hot.
- EN  out  1  one-cycle pulse: payment complete.
- z_1  out  1  one-cycle pulse: dispense hold time elapsed.
- z2  out  1  one-cycle pulse: change hold time elapsed.
- V  out  3  change code, one-cycle: 001 = 1 unit, 010 = 2 units, 000 = none.
- credit  out  4  current credit in units.
- busy  out  1  high in VEND, CHANGE, CHG_WAIT and HOLD.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, credit=0, remainder=0.
  - EN, z_1, z2, busy=0; V=000.
  - Debouncers and timers cleared.
  - Applies immediately, including mid-change; any undelivered remainder is discarded.
- Debounce:
  - Each raw input passes a 2-FF synchronizer plus a counter.
  - A level is accepted after DEB_CYCLES consecutive equal samples.
  - An accepted 0→1 transition yields exactly one internal pulse. The next pulse requires an accepted return to 0.
  - Latency from a clean rising edge to the credit update is 2+DEB_CYCLES+1 cycles.
- Credit:
  - Coin pulses are accepted only in IDLE and COLLECT. Pulses in any other state are dropped.
  - coin1 adds 1 and coin2 adds 2; pulses in the same cycle add 3.
  - Credit saturates at 15 and never wraps.
- Price decode:
  - P one-hot selects PRICE0..3.
  - P=0000 or multi-hot is invalid.
- State IDLE:
  - Entered when P is invalid. Credit is held and accumulates.
  - Goes to COLLECT when P becomes valid.
- State COLLECT:
  - Returns to IDLE if P becomes invalid; credit is retained.
  - If credit ≥ price, goes to VEND on the next edge. This includes a coin arriving in the same cycle; the comparison uses updated credit one cycle later.
- State VEND (1 cycle):
  - EN=1; remainder=credit−price; credit=0; dispense timer loaded.
  - Next state is CHANGE if remainder>0, else HOLD.
- State CHANGE (1 cycle):
  - If remainder≥2: V=010, remainder−=2. Otherwise V=001, remainder−=1.
  - Change timer loaded; next state CHG_WAIT.
- State CHG_WAIT:
  - z2=1 exactly CHG_CYCLES cycles after the V cycle.
  - In the z2 cycle, goes to CHANGE if remainder>0, else HOLD.
- State HOLD:
  - Waits for dispense done, then goes to IDLE.
  - Dispense done is a sticky flag set by z_1; it is cleared on entry to IDLE.
- Dispense timer:
  - z_1=1 exactly DISP_CYCLES cycles after EN, independent of change activity. It may coincide with V or z2.
- busy is the registered state decode; it is low only in IDLE and COLLECT.
- All outputs are registered.

Optional Feature:
- Macro: PAYMENT_CANCEL_EN.
- Defined:
  - cancel uses the same debouncer.
  - An accepted cancel pulse in IDLE or COLLECT with credit>0 gives remainder=credit, credit=0, then CHANGE.
  - No EN and no z_1 are issued. After the last z2, returns directly to IDLE, skipping the HOLD wait.
  - A cancel with credit=0, or in any other state, is ignored.
  - If cancel and the VEND condition occur in the same cycle, VEND wins.
- Not defined: the cancel port exists but has no effect, and the debouncer for it is not instantiated.

Test Plan:
- P=0001, two clean coin1 presses (each held 10 cycles) → credit 1 then 2; EN one cycle; credit 0; V stays 000; z_1 exactly 8 cycles after EN; busy drops the cycle after entering IDLE.
- coin1 toggling every cycle for 3 cycles, then stable high for 10 → credit increments by exactly 1.
- P=0000, three coin2 presses → credit 6, no EN. Then P=0001 → EN; V=010, z2 4 cycles later; V=010, z2; then HOLD until z_1; then IDLE.
- P=1000, three coin2 presses → EN at credit 6; next cycle V=001; z2 4 cycles later; coin pulses during busy leave credit at 0.
- P=0000, eight coin2 presses → credit saturates at 15. Assert reset low during a later CHG_WAIT → all outputs 0 and credit 0 immediately.
- With PAYMENT_CANCEL_EN: credit 3, P=0100, cancel press → V=010, z2, V=001, z2, IDLE; no EN, no z_1. Without the macro, the same stimulus leaves credit 3.

Source files
------------

// File: rtl/payment_controller_if.sv
// Coin/selection inputs and vend/change outputs of the payment stage.
interface payment_controller_if;
  logic       coin1;
  logic       coin2;
  logic       cancel;
  logic [3:0] P;
  logic       EN;
  logic       z_1;
  logic       z2;
  logic [2:0] V;
  logic [3:0] credit;
  logic       busy;

  modport master (
    output coin1, coin2, cancel, P,
    input  EN, z_1, z2, V, credit, busy
  );

  modport slave (
    input  coin1, coin2, cancel, P,
    output EN, z_1, z2, V, credit, busy
  );
endinterface

// File: rtl/payment_controller.sv
// Vending payment stage: coin debounce, credit, vend release, serial change and hold timers.
// Refund button support is compiled in when PAYMENT_CANCEL_EN is defined.
module payment_controller #(
  parameter int         DEB_CYCLES  = 4,
  parameter int         DISP_CYCLES = 8,
  parameter int         CHG_CYCLES  = 4,
  parameter logic [3:0] PRICE0      = 4'd2,
  parameter logic [3:0] PRICE1      = 4'd3,
  parameter logic [3:0] PRICE2      = 4'd4,
  parameter logic [3:0] PRICE3      = 4'd5
) (
  input logic                  clock,
  input logic                  reset,
  payment_controller_if.slave  bus
);
`ifdef PAYMENT_CANCEL_EN
  localparam int NDEB = 3;
`else
  localparam int NDEB = 2;
`endif
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int DISP_W = $clog2(DISP_CYCLES + 1);
  localparam int CHG_W  = $clog2(CHG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    VEND     = 3'd2,
    CHANGE   = 3'd3,
    CHG_WAIT = 3'd4,
    HOLD     = 3'd5
  } state_t;

  function automatic logic [3:0] price_of(input logic [3:0] p);
    case (p)
      4'b0001: price_of = PRICE0;
      4'b0010: price_of = PRICE1;
      4'b0100: price_of = PRICE2;
      4'b1000: price_of = PRICE3;
      default: price_of = 4'd0;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [3:0] p);
    is_onehot = (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  state_t             state_r, next_state_s;
  logic [NDEB-1:0]    raw_s, sync1_r, sync2_r, stable_r, pulse_r;
  logic [DEB_W-1:0]   cnt_r [NDEB];
  logic [3:0]         credit_r, remainder_r, price_r, price_s, rem_src_s, credit_sat_s;
  logic [4:0]         credit_sum_s;
  logic [DISP_W-1:0]  disp_cnt_r;
  logic [CHG_W-1:0]   chg_cnt_r;
  logic               en_r, z1_r, z2_r, busy_r, disp_done_r, cancel_mode_r;
  logic [2:0]         v_r;
  logic               valid_s, open_s, vend_go_s, cancel_go_s, cancel_p_s;

`ifdef PAYMENT_CANCEL_EN
  assign raw_s      = {bus.cancel, bus.coin2, bus.coin1};
  assign cancel_p_s = pulse_r[2];
`else
  logic unused_cancel_s;
  assign unused_cancel_s = bus.cancel;
  assign raw_s           = {bus.coin2, bus.coin1};
  assign cancel_p_s      = 1'b0;
`endif

  // Synchronize each raw contact, then accept a new level only after DEB_CYCLES equal samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      stable_r <= '0;
      pulse_r  <= '0;
      for (int i = 0; i < NDEB; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < NDEB; i++) begin
        pulse_r[i] <= 1'b0;
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == DEB_W'(DEB_CYCLES - 1)) begin
          cnt_r[i]    <= '0;
          stable_r[i] <= sync2_r[i];
          pulse_r[i]  <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign price_s      = price_of(bus.P);
  assign valid_s      = is_onehot(bus.P);
  assign open_s       = (state_r == IDLE) || (state_r == COLLECT);
  assign vend_go_s    = (state_r == COLLECT) && valid_s && (credit_r >= price_s);
  assign cancel_go_s  = open_s && cancel_p_s && (credit_r != 4'd0) && !vend_go_s;
  assign credit_sum_s = {1'b0, credit_r} + {4'd0, pulse_r[0]} + {3'd0, pulse_r[1], 1'b0};
  assign credit_sat_s = credit_sum_s[4] ? 4'd15 : credit_sum_s[3:0];

  // Amount still owed at the moment a change code is about to be issued.
  always_comb begin
    rem_src_s = credit_r;
    if (state_r == VEND) begin
      rem_src_s = credit_r - price_r;
    end else if (state_r == CHG_WAIT) begin
      rem_src_s = remainder_r;
    end else begin
      rem_src_s = credit_r;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cancel_go_s)  next_state_s = CHANGE;
        else if (valid_s) next_state_s = COLLECT;
        else              next_state_s = IDLE;
      end
      COLLECT: begin
        if (vend_go_s)        next_state_s = VEND;
        else if (cancel_go_s) next_state_s = CHANGE;
        else if (!valid_s)    next_state_s = IDLE;
        else                  next_state_s = COLLECT;
      end
      VEND: begin
        if (credit_r > price_r) next_state_s = CHANGE;
        else                    next_state_s = HOLD;
      end
      CHANGE: next_state_s = CHG_WAIT;
      CHG_WAIT: begin
        if (!z2_r)                     next_state_s = CHG_WAIT;
        else if (remainder_r != 4'd0)  next_state_s = CHANGE;
        else if (cancel_mode_r)        next_state_s = IDLE;
        else                           next_state_s = HOLD;
      end
      HOLD: begin
        if (disp_done_r || z1_r) next_state_s = IDLE;
        else                     next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register, credit and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      credit_r      <= 4'd0;
      price_r       <= 4'd0;
      busy_r        <= 1'b0;
      disp_done_r   <= 1'b0;
      cancel_mode_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= !open_s;
      if ((state_r == VEND) || cancel_go_s) begin
        credit_r <= 4'd0;
      end else if (open_s) begin
        credit_r <= credit_sat_s;
      end
      if (vend_go_s) price_r <= price_s;
      if ((next_state_s == IDLE) && (state_r != IDLE)) disp_done_r <= 1'b0;
      else if (z1_r)                                   disp_done_r <= 1'b1;
      if (cancel_go_s)                                 cancel_mode_r <= 1'b1;
      else if (next_state_s == IDLE)                   cancel_mode_r <= 1'b0;
    end
  end

  // Pulse outputs, change codes and the two hold timers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_r        <= 1'b0;
      z1_r        <= 1'b0;
      z2_r        <= 1'b0;
      v_r         <= 3'b000;
      remainder_r <= 4'd0;
      disp_cnt_r  <= '0;
      chg_cnt_r   <= '0;
    end else begin
      en_r <= 1'b0;
      z1_r <= 1'b0;
      z2_r <= 1'b0;
      v_r  <= 3'b000;
      if (vend_go_s) begin
        en_r       <= 1'b1;
        disp_cnt_r <= DISP_W'(DISP_CYCLES);
      end else if (disp_cnt_r != '0) begin
        disp_cnt_r <= disp_cnt_r - 1'b1;
        z1_r       <= (disp_cnt_r == DISP_W'(1));
      end
      if (next_state_s == CHANGE) begin
        chg_cnt_r <= CHG_W'(CHG_CYCLES);
        if (rem_src_s >= 4'd2) begin
          v_r         <= 3'b010;
          remainder_r <= rem_src_s - 4'd2;
        end else begin
          v_r         <= 3'b001;
          remainder_r <= rem_src_s - 4'd1;
        end
      end else if (chg_cnt_r != '0) begin
        chg_cnt_r <= chg_cnt_r - 1'b1;
        z2_r      <= (chg_cnt_r == CHG_W'(1));
      end
    end
  end

  assign bus.EN     = en_r;
  assign bus.z_1    = z1_r;
  assign bus.z2     = z2_r;
  assign bus.V      = v_r;
  assign bus.credit = credit_r;
  assign bus.busy   = busy_r;
endmodule

// File: tb/tb_payment_controller.sv
// Directed self-checking bench for payment_controller; honours PAYMENT_CANCEL_EN.
module tb_payment_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  payment_controller_if bus ();

  payment_controller dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Event log owned by this monitor; tests snapshot counts and compare offsets.
  int       cyc = 0, en_cnt = 0, z1_cnt = 0, z2_cnt = 0, v_cnt = 0;
  int       en_cyc = 0, z1_cyc = 0, busy_fall = 0;
  int       z2_cyc [64];
  int       v_cyc [64];
  logic [2:0] v_val [64];
  logic     prev_busy = 1'b0;

  always @(posedge clock) begin
    #1;
    cyc <= cyc + 1;
    if (bus.EN === 1'b1) begin en_cnt <= en_cnt + 1; en_cyc <= cyc; end
    if (bus.z_1 === 1'b1) begin z1_cnt <= z1_cnt + 1; z1_cyc <= cyc; end
    if (bus.z2 === 1'b1) begin
      if (z2_cnt < 64) z2_cyc[z2_cnt] <= cyc;
      z2_cnt <= z2_cnt + 1;
    end
    if (bus.V !== 3'b000) begin
      if (v_cnt < 64) begin v_cyc[v_cnt] <= cyc; v_val[v_cnt] <= bus.V; end
      v_cnt <= v_cnt + 1;
    end
    if (prev_busy && (bus.busy === 1'b0)) busy_fall <= cyc;
    prev_busy <= bus.busy;
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int which, input int hi, input int lo);
    if (which == 1) bus.coin1 = 1'b1;
    else if (which == 2) bus.coin2 = 1'b1;
    else bus.cancel = 1'b1;
    run(hi);
    bus.coin1 = 1'b0; bus.coin2 = 1'b0; bus.cancel = 1'b0;
    run(lo);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.coin1 = 1'b0; bus.coin2 = 1'b0; bus.cancel = 1'b0; bus.P = 4'b0000;
    run(2);
    reset = 1'b1;
    run(2);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.coin1 = 1'b0; bus.coin2 = 1'b0; bus.cancel = 1'b0; bus.P = 4'b0000;
    run(2);
    checks++;
    if (bus.credit !== 4'd0) begin failures++; $display("FAIL reset_credit got=%0d want=0", bus.credit); end
    checks++;
    if ({bus.EN, bus.z_1, bus.z2, bus.V, bus.busy} !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs got EN=%b z_1=%b z2=%b V=%b busy=%b want all 0", bus.EN, bus.z_1, bus.z2, bus.V, bus.busy);
    end
    reset = 1'b1;
    run(2);
  endtask

  task automatic test_single_vend();
    int e0, z0, v0;
    apply_reset();
    bus.P = 4'b0001;
    run(3);
    e0 = en_cnt; z0 = z1_cnt; v0 = v_cnt;
    bus.coin1 = 1'b1;
    run(6);
    checks++;
    if (bus.credit !== 4'd0) begin failures++; $display("FAIL latency_early got=%0d want=0", bus.credit); end
    run(1);
    checks++;
    if (bus.credit !== 4'd1) begin failures++; $display("FAIL latency_credit1 got=%0d want=1", bus.credit); end
    run(3);
    bus.coin1 = 1'b0;
    run(10);
    bus.coin1 = 1'b1;
    for (int i = 0; i < 40 && en_cnt == e0; i++) run(1);
    checks++;
    if (en_cnt - e0 !== 1) begin failures++; $display("FAIL vend_en_seen got=%0d want=1", en_cnt - e0); end
    run(1);
    checks++;
    if (bus.credit !== 4'd0) begin failures++; $display("FAIL vend_credit_clear got=%0d want=0", bus.credit); end
    run(8);
    bus.coin1 = 1'b0;
    run(20);
    checks++;
    if (en_cnt - e0 !== 1) begin failures++; $display("FAIL vend_en_once got=%0d want=1", en_cnt - e0); end
    checks++;
    if (z1_cnt - z0 !== 1 || z1_cyc - en_cyc !== 8) begin
      failures++; $display("FAIL vend_z1 count=%0d offset=%0d want 1 and 8", z1_cnt - z0, z1_cyc - en_cyc);
    end
    checks++;
    if (v_cnt !== v0) begin failures++; $display("FAIL vend_no_change got=%0d codes want=0", v_cnt - v0); end
    checks++;
    if (busy_fall - en_cyc !== 10 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL vend_busy_fall offset=%0d busy=%b want 10 and 0", busy_fall - en_cyc, bus.busy);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    bus.coin1 = 1'b1; run(1);
    bus.coin1 = 1'b0; run(1);
    bus.coin1 = 1'b1; run(1);
    run(10);
    bus.coin1 = 1'b0;
    run(12);
    checks++;
    if (bus.credit !== 4'd1) begin failures++; $display("FAIL bounce_credit got=%0d want=1", bus.credit); end
  endtask

  task automatic test_change_two();
    int e0, v0, w0;
    apply_reset();
    e0 = en_cnt;
    for (int k = 0; k < 3; k++) press(2, 10, 10);
    checks++;
    if (bus.credit !== 4'd6 || en_cnt !== e0) begin
      failures++; $display("FAIL idle_accum credit=%0d en=%0d want 6 and 0", bus.credit, en_cnt - e0);
    end
    v0 = v_cnt; w0 = z2_cnt;
    bus.P = 4'b0001;
    for (int i = 0; i < 10 && en_cnt == e0; i++) run(1);
    run(20);
    checks++;
    if (en_cnt - e0 !== 1) begin failures++; $display("FAIL chg2_en got=%0d want=1", en_cnt - e0); end
    checks++;
    if (v_cnt - v0 !== 2 || v_val[v0] !== 3'b010 || v_val[v0+1] !== 3'b010) begin
      failures++; $display("FAIL chg2_codes n=%0d v0=%b v1=%b want 2,010,010", v_cnt - v0, v_val[v0], v_val[v0+1]);
    end
    checks++;
    if (v_cyc[v0] - en_cyc !== 1 || v_cyc[v0+1] - en_cyc !== 6) begin
      failures++; $display("FAIL chg2_v_timing got=%0d,%0d want=1,6", v_cyc[v0] - en_cyc, v_cyc[v0+1] - en_cyc);
    end
    checks++;
    if (z2_cnt - w0 !== 2 || z2_cyc[w0] - en_cyc !== 5 || z2_cyc[w0+1] - en_cyc !== 10) begin
      failures++; $display("FAIL chg2_z2 n=%0d at %0d,%0d want 2 at 5,10", z2_cnt - w0, z2_cyc[w0] - en_cyc, z2_cyc[w0+1] - en_cyc);
    end
    checks++;
    if (z1_cyc - en_cyc !== 8 || busy_fall - en_cyc !== 13) begin
      failures++; $display("FAIL chg2_hold z1=%0d busy_fall=%0d want 8,13", z1_cyc - en_cyc, busy_fall - en_cyc);
    end
  endtask

  task automatic test_change_one();
    int e0, v0, w0;
    apply_reset();
    bus.P = 4'b1000;
    run(2);
    e0 = en_cnt;
    press(2, 10, 10);
    press(2, 10, 10);
    checks++;
    if (bus.credit !== 4'd4 || en_cnt !== e0) begin
      failures++; $display("FAIL p3_below_price credit=%0d en=%0d want 4 and 0", bus.credit, en_cnt - e0);
    end
    v0 = v_cnt; w0 = z2_cnt;
    bus.coin2 = 1'b1;
    for (int i = 0; i < 30 && en_cnt == e0; i++) run(1);
    bus.coin1 = 1'b1;
    run(10);
    bus.coin1 = 1'b0; bus.coin2 = 1'b0;
    run(20);
    checks++;
    if (v_cnt - v0 !== 1 || v_val[v0] !== 3'b001 || v_cyc[v0] - en_cyc !== 1) begin
      failures++; $display("FAIL chg1_code n=%0d v=%b offset=%0d want 1,001,1", v_cnt - v0, v_val[v0], v_cyc[v0] - en_cyc);
    end
    checks++;
    if (z2_cnt - w0 !== 1 || z2_cyc[w0] - en_cyc !== 5) begin
      failures++; $display("FAIL chg1_z2 n=%0d offset=%0d want 1,5", z2_cnt - w0, z2_cyc[w0] - en_cyc);
    end
    checks++;
    if (busy_fall - en_cyc !== 10) begin failures++; $display("FAIL chg1_busy_fall got=%0d want=10", busy_fall - en_cyc); end
    checks++;
    if (bus.credit !== 4'd0) begin failures++; $display("FAIL busy_coin_dropped got=%0d want=0", bus.credit); end
  endtask

  task automatic test_saturate_reset();
    int v0, v1, z10;
    apply_reset();
    for (int k = 0; k < 8; k++) press(2, 10, 10);
    checks++;
    if (bus.credit !== 4'd15) begin failures++; $display("FAIL saturate got=%0d want=15", bus.credit); end
    v0 = v_cnt;
    bus.P = 4'b0100;
    for (int i = 0; i < 20 && v_cnt == v0; i++) run(1);
    checks++;
    if (v_cnt - v0 !== 1 || v_val[v0] !== 3'b010) begin
      failures++; $display("FAIL sat_first_code n=%0d v=%b want 1,010", v_cnt - v0, v_val[v0]);
    end
    run(2);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.credit !== 4'd0) begin failures++; $display("FAIL async_reset_credit got=%0d want=0", bus.credit); end
    checks++;
    if ({bus.EN, bus.z_1, bus.z2, bus.V, bus.busy} !== 7'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got EN=%b z_1=%b z2=%b V=%b busy=%b want all 0", bus.EN, bus.z_1, bus.z2, bus.V, bus.busy);
    end
    bus.P = 4'b0000;
    run(2);
    reset = 1'b1;
    v1 = v_cnt; z10 = z1_cnt;
    run(30);
    checks++;
    if (v_cnt !== v1 || z1_cnt !== z10 || bus.credit !== 4'd0) begin
      failures++; $display("FAIL post_reset_quiet codes=%0d z1=%0d credit=%0d want 0,0,0", v_cnt - v1, z1_cnt - z10, bus.credit);
    end
  endtask

  task automatic test_cancel();
    int e0, z10, v0, w0;
    apply_reset();
    press(1, 10, 10);
    press(2, 10, 10);
    bus.P = 4'b0100;
    run(3);
    checks++;
    if (bus.credit !== 4'd3) begin failures++; $display("FAIL cancel_setup got=%0d want=3", bus.credit); end
    e0 = en_cnt; z10 = z1_cnt; v0 = v_cnt; w0 = z2_cnt;
    press(3, 10, 10);
    run(30);
`ifdef PAYMENT_CANCEL_EN
    checks++;
    if (en_cnt !== e0 || z1_cnt !== z10) begin
      failures++; $display("FAIL cancel_no_vend en=%0d z1=%0d want 0,0", en_cnt - e0, z1_cnt - z10);
    end
    checks++;
    if (v_cnt - v0 !== 2 || v_val[v0] !== 3'b010 || v_val[v0+1] !== 3'b001 || v_cyc[v0+1] - v_cyc[v0] !== 5) begin
      failures++; $display("FAIL cancel_codes n=%0d v=%b,%b gap=%0d want 2,010,001,5", v_cnt - v0, v_val[v0], v_val[v0+1], v_cyc[v0+1] - v_cyc[v0]);
    end
    checks++;
    if (z2_cnt - w0 !== 2 || z2_cyc[w0] - v_cyc[v0] !== 4 || z2_cyc[w0+1] - v_cyc[v0+1] !== 4) begin
      failures++; $display("FAIL cancel_z2 n=%0d gaps=%0d,%0d want 2,4,4", z2_cnt - w0, z2_cyc[w0] - v_cyc[v0], z2_cyc[w0+1] - v_cyc[v0+1]);
    end
    checks++;
    if (busy_fall - z2_cyc[w0+1] !== 2 || bus.credit !== 4'd0) begin
      failures++; $display("FAIL cancel_to_idle busy_gap=%0d credit=%0d want 2,0", busy_fall - z2_cyc[w0+1], bus.credit);
    end
`else
    checks++;
    if (bus.credit !== 4'd3 || v_cnt !== v0 || en_cnt !== e0) begin
      failures++; $display("FAIL cancel_ignored credit=%0d codes=%0d en=%0d want 3,0,0", bus.credit, v_cnt - v0, en_cnt - e0);
    end
`endif
  endtask

  initial begin
    bus.coin1 = 1'b0; bus.coin2 = 1'b0; bus.cancel = 1'b0; bus.P = 4'b0000;
    test_reset();
    test_single_vend();
    test_bounce();
    test_change_two();
    test_change_one();
    test_saturate_reset();
    test_cancel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
